tsync_loop_controller: RTL and testbench

Acquisition/tracking controller for the QPSK symbol-timing recovery loop. Monitors gated timing-error samples, one per symbol, from the ZCTED/zero-stuffer path and computes a windowed mean-|e| lock metric. It sequences the loop through idle, acquisition and tracking, drives the PI loop-filter gains and an integrator-clear pulse, and reports lock.

---
 rtl/tsync_loop_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_tsync_loop_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsync_loop_controller.sv
// -----------------------------------------------------------------------------
// tsync_loop_controller
//
// Acquisition/tracking controller for the QPSK symbol-timing recovery loop.
// Accumulates |e_k| over windows of 2^WIN_LOG2 gated error samples to form a
// mean-|e| lock metric. The metric steps the loop through IDLE -> ACQ -> TRACK.
// The controller selects the PI loop-filter gains, pulses an integrator clear
// and reports lock.
//
// Optional feature (compile-time macro TSYNC_ACQ_TIMEOUT_EN):
//   ACQ counts completed windows. After ACQ_TIMEOUT windows without lock it
//   restarts acquisition: loop_clear pulses, the window and good counters
//   clear, and acq_retries increments (saturating at 255). Without the macro,
//   ACQ persists indefinitely and acq_retries stays 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       run request; low forces IDLE on the next edge
//   e_valid      error sample strobe
//   e_k          signed timing error sample (Q1.15)
//   kp_acq/ki_acq  acquisition gains
//   kp_trk/ki_trk  tracking gains
//   lock_thr     window mean |e| below this counts as a good window
//   unlock_thr   window mean |e| above this counts as a bad window
//   kp_out/ki_out  registered gains to the loop filter
//   loop_clear   one-cycle pulse that clears the loop-filter integrator and NCO
//   locked       high in TRACK
//   state        00 IDLE, 01 ACQ, 10 TRACK
//   metric       mean |e| of the last completed window
//   acq_retries  saturating count of acquisition timeouts
// -----------------------------------------------------------------------------
module tsync_loop_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int WIN_LOG2    = 6,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2,
    parameter int ACQ_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          e_valid,
    input  logic signed [DATA_WIDTH-1:0]  e_k,
    input  logic [COEFF_WIDTH-1:0]        kp_acq,
    input  logic [COEFF_WIDTH-1:0]        ki_acq,
    input  logic [COEFF_WIDTH-1:0]        kp_trk,
    input  logic [COEFF_WIDTH-1:0]        ki_trk,
    input  logic [DATA_WIDTH-1:0]         lock_thr,
    input  logic [DATA_WIDTH-1:0]         unlock_thr,
    output logic [COEFF_WIDTH-1:0]        kp_out,
    output logic [COEFF_WIDTH-1:0]        ki_out,
    output logic                          loop_clear,
    output logic                          locked,
    output logic [1:0]                    state,
    output logic [DATA_WIDTH-1:0]         metric,
    output logic [7:0]                    acq_retries
);

`ifdef TSYNC_ACQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int ACC_W = DATA_WIDTH + WIN_LOG2;

    // Full-scale negative input and the largest positive magnitude it saturates to.
    localparam logic [DATA_WIDTH-1:0] NEG_FS  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACQ   = 2'b01,
        S_TRACK = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    e_bits, e_abs;
    logic [ACC_W-1:0]         acc_q, acc_sum;
    logic [WIN_LOG2-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0]    metric_q;
    logic                     wdone_q;
    logic [7:0]               good_q, bad_q, awin_q, retries_q;
    logic                     good_win, bad_win;
    logic                     lock_hit, unlock_hit, timeout_hit;
    logic                     win_clear;
    logic [COEFF_WIDTH-1:0]   kp_d, ki_d, kp_q, ki_q;
    logic                     clear_d, clear_q;

    // ---------------------------------------------------------------- |e_k|
    assign e_bits = e_k;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        e_abs = e_bits;
        if (e_bits == NEG_FS)
            e_abs = MAG_MAX;
        else if (e_bits[DATA_WIDTH-1])
            e_abs = ~e_bits + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end

    assign acc_sum = acc_q + ACC_W'(e_abs);

    // ------------------------------------------------------ window decisions
    // Decisions use the metric registered on the previous edge, qualified by
    // window_done, so state changes land two edges after the final sample.
    assign good_win   = metric_q < lock_thr;
    assign bad_win    = metric_q > unlock_thr;
    assign lock_hit   = wdone_q && good_win && (good_q == 8'(LOCK_CNT - 1));
    assign unlock_hit = wdone_q && bad_win  && (bad_q  == 8'(UNLOCK_CNT - 1));
    // Lock takes priority over a timeout that falls on the same window.
    assign timeout_hit = TIMEOUT_EN && enable && (state_q == S_ACQ) && wdone_q &&
                         !lock_hit && (awin_q == 8'(ACQ_TIMEOUT - 1));

    // ------------------------------------------------------- state register
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ACQ;
                S_ACQ:   if (lock_hit)   state_d = S_TRACK;
                S_TRACK: if (unlock_hit) state_d = S_ACQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Any transition or timeout restart throws away the window in flight,
    // including a sample arriving in that same cycle. IDLE keeps it empty.
    assign win_clear = (state_d != state_q) || timeout_hit || (state_q == S_IDLE);

    // ---------------------------------------------------------- output decode
    // Gains are decoded from next state so they change on the same edge as state.
    always_comb begin
        kp_d    = '0;
        ki_d    = '0;
        clear_d = timeout_hit || ((state_d == S_ACQ) && (state_q != S_ACQ));
        case (state_d)
            S_ACQ: begin
                kp_d = kp_acq;
                ki_d = ki_acq;
            end
            S_TRACK: begin
                kp_d = kp_trk;
                ki_d = ki_trk;
            end
            default: begin
                kp_d = '0;
                ki_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kp_q    <= '0;
            ki_q    <= '0;
            clear_q <= 1'b0;
        end else begin
            kp_q    <= kp_d;
            ki_q    <= ki_d;
            clear_q <= clear_d;
        end
    end

    // ------------------------------------------------------ window accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            metric_q <= '0;
            wdone_q  <= 1'b0;
        end else begin
            wdone_q <= 1'b0;
            if (win_clear) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (e_valid) begin
                if (cnt_q == '1) begin
                    metric_q <= acc_sum[ACC_W-1:WIN_LOG2];
                    wdone_q  <= 1'b1;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + WIN_LOG2'(1);
                end
            end
        end
    end

    // --------------------------------------------------- good/bad/window counts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            good_q <= '0;
            bad_q  <= '0;
            awin_q <= '0;
        end else if (win_clear) begin
            good_q <= '0;
            bad_q  <= '0;
            awin_q <= '0;
        end else if (wdone_q) begin
            case (state_q)
                S_ACQ: begin
                    good_q <= good_win ? good_q + 8'd1 : 8'd0;
                    awin_q <= awin_q + 8'd1;
                end
                S_TRACK: bad_q <= bad_win ? bad_q + 8'd1 : 8'd0;
                default: ;
            endcase
        end
    end

    // Retry count survives enable drops; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            retries_q <= '0;
        else if (timeout_hit && (retries_q != 8'hFF))
            retries_q <= retries_q + 8'd1;
    end

    assign kp_out      = kp_q;
    assign ki_out      = ki_q;
    assign loop_clear  = clear_q;
    assign locked      = (state_q == S_TRACK);
    assign state       = state_q;
    assign metric      = metric_q;
    assign acq_retries = retries_q;

endmodule

// File: tb/tb_tsync_loop_controller.sv
// -----------------------------------------------------------------------------
// Testbench for tsync_loop_controller. A behavioural model computes window
// means with integer arithmetic and applies the lock/unlock/timeout rules
// each cycle; all DUT outputs are compared every cycle. Directed stimulus
// covers the lock, unlock, threshold-equality and reset scenarios.
// Randomized stimulus then exercises mixed regimes.
// -----------------------------------------------------------------------------
module tb_tsync_loop_controller;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int WL = 6;
    localparam int LC = 4;
    localparam int UC = 2;
`ifdef TSYNC_ACQ_TIMEOUT_EN
    localparam int AT    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int AT    = 64;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int WIN = 1 << WL;

    logic                 clk = 1'b0;
    logic                 rst_n, enable, e_valid;
    logic signed [DW-1:0] e_k;
    logic [CW-1:0]        kp_acq, ki_acq, kp_trk, ki_trk;
    logic [DW-1:0]        lock_thr, unlock_thr;
    logic [CW-1:0]        kp_out, ki_out;
    logic                 loop_clear, locked;
    logic [1:0]           state;
    logic [DW-1:0]        metric;
    logic [7:0]           acq_retries;

    always #5 clk = ~clk;

    tsync_loop_controller #(
        .DATA_WIDTH (DW),
        .COEFF_WIDTH(CW),
        .WIN_LOG2   (WL),
        .LOCK_CNT   (LC),
        .UNLOCK_CNT (UC),
        .ACQ_TIMEOUT(AT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .e_valid    (e_valid),
        .e_k        (e_k),
        .kp_acq     (kp_acq),
        .ki_acq     (ki_acq),
        .kp_trk     (kp_trk),
        .ki_trk     (ki_trk),
        .lock_thr   (lock_thr),
        .unlock_thr (unlock_thr),
        .kp_out     (kp_out),
        .ki_out     (ki_out),
        .loop_clear (loop_clear),
        .locked     (locked),
        .state      (state),
        .metric     (metric),
        .acq_retries(acq_retries)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Phase of the loop: 0 idle, 1 acquiring, 2 tracking.
    int m_phase, m_sum, m_n, m_mean, m_good, m_bad, m_wins, m_retries;
    int m_kp, m_ki;
    bit m_clear, m_closed;

    function automatic int mag(input logic signed [DW-1:0] v);
        int x;
        x = int'(v);
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  nxt, g, b;
        bit  restart, closed_now;
        if (!rst_n) begin
            m_phase = 0; m_sum = 0; m_n = 0; m_mean = 0; m_good = 0; m_bad = 0;
            m_wins = 0; m_retries = 0; m_kp = 0; m_ki = 0; m_clear = 0; m_closed = 0;
            return;
        end
        g = m_good;
        b = m_bad;
        if (m_closed) begin
            g = (m_mean < int'(lock_thr))   ? m_good + 1 : 0;
            b = (m_mean > int'(unlock_thr)) ? m_bad + 1  : 0;
        end
        nxt     = m_phase;
        restart = 0;
        if (!enable)
            nxt = 0;
        else if (m_phase == 0)
            nxt = 1;
        else if (m_phase == 1 && m_closed) begin
            if (g == LC) nxt = 2;
            else if (TO_EN && (m_wins + 1 == AT)) restart = 1;
        end else if (m_phase == 2 && m_closed && b == UC)
            nxt = 1;

        m_clear    = (nxt == 1 && m_phase != 1) || restart;
        closed_now = 0;
        if (nxt != m_phase || restart || m_phase == 0) begin
            m_sum = 0; m_n = 0; m_good = 0; m_bad = 0; m_wins = 0;
        end else begin
            if (m_closed && m_phase == 1) begin
                m_good = g;
                m_wins++;
            end
            if (m_closed && m_phase == 2) m_bad = b;
            if (e_valid) begin
                m_sum += mag(e_k);
                m_n++;
                if (m_n == WIN) begin
                    m_mean     = m_sum / WIN;
                    m_sum      = 0;
                    m_n        = 0;
                    closed_now = 1;
                end
            end
        end
        if (restart && m_retries < 255) m_retries++;
        m_kp     = (nxt == 1) ? int'(kp_acq) : (nxt == 2) ? int'(kp_trk) : 0;
        m_ki     = (nxt == 1) ? int'(ki_acq) : (nxt == 2) ? int'(ki_trk) : 0;
        m_phase  = nxt;
        m_closed = closed_now;
    endtask

    task automatic compare_all();
        check("state",       32'(state),       32'(m_phase));
        check("kp_out",      32'(kp_out),      32'(m_kp));
        check("ki_out",      32'(ki_out),      32'(m_ki));
        check("loop_clear",  32'(loop_clear),  32'(m_clear));
        check("locked",      32'(locked),      32'(m_phase == 2));
        check("metric",      32'(metric),      32'(m_mean));
        check("acq_retries", 32'(acq_retries), 32'(m_retries));
    endtask

    // Drives one cycle of inputs, steps the model, then compares after the edge.
    task automatic tick(input logic r, input logic en, input logic v, input logic signed [DW-1:0] e);
        rst_n   = r;
        enable  = en;
        e_valid = v;
        e_k     = e;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic feed_windows(input int nwin, input logic signed [DW-1:0] e);
        for (int i = 0; i < nwin * WIN; i++) tick(1'b1, 1'b1, 1'b1, e);
    endtask

    function automatic logic signed [DW-1:0] rand_err(input int lim);
        int m;
        m = int'($urandom_range(0, lim));
        return DW'(($urandom % 2) ? -m : m);
    endfunction

    initial begin
        kp_acq     = CW'($urandom) | 16'h0001;
        ki_acq     = CW'($urandom) | 16'h0002;
        kp_trk     = CW'($urandom) | 16'h0004;
        ki_trk     = CW'($urandom) | 16'h0008;
        lock_thr   = 16'h0400;
        unlock_thr = 16'h1000;
        rst_n = 1'b0; enable = 1'b0; e_valid = 1'b0; e_k = '0;
        @(posedge clk);
        #1;

        // Reset state.
        repeat (2) tick(1'b0, 1'b0, 1'b0, '0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_metric", 32'(metric), 32'd0);

        // Enable: ACQ with acq gains and a single clear pulse.
        tick(1'b1, 1'b1, 1'b0, '0);
        check("en_state", 32'(state), 32'd1);
        check("en_clear", 32'(loop_clear), 32'd1);
        check("en_kp", 32'(kp_out), 32'(kp_acq));
        tick(1'b1, 1'b1, 1'b0, '0);
        check("en_clear_drop", 32'(loop_clear), 32'd0);

        // Four good windows at +0x0100 lock two edges after the final sample.
        feed_windows(LC, 16'sh0100);
        check("lock_metric", 32'(metric), 32'h0100);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("lock_state", 32'(state), 32'd2);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_kp", 32'(kp_out), 32'(kp_trk));

        // Tracking: bad, clean, bad keeps TRACK; a second consecutive bad drops.
        feed_windows(1, 16'sh2000);
        feed_windows(1, 16'sh0800);
        feed_windows(1, 16'sh2000);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("trk_hold", 32'(state), 32'd2);
        feed_windows(1, 16'sh2000);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("unlock_state", 32'(state), 32'd1);
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_clear", 32'(loop_clear), 32'd1);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("unlock_clear_drop", 32'(loop_clear), 32'd0);

        // Full-scale alternating samples saturate to 0x7FFF.
        for (int i = 0; i < 2 * WIN; i++)
            tick(1'b1, 1'b1, 1'b1, (i % 2) ? 16'sh7FFF : 16'sh8000);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("fs_metric", 32'(metric), 32'h7FFF);
        check("fs_state", 32'(state), 32'd1);

        // Metric equal to lock_thr never counts as good.
        feed_windows(LC + 1, 16'sh0400);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("eq_metric", 32'(metric), 32'h0400);
        check("eq_state", 32'(state), 32'd1);

        // Timeout scenario from a fresh reset; then enable drop holds retries.
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b0, '0);
        feed_windows(12, 16'sh4000);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("to_retries", 32'(acq_retries), TO_EN ? 32'd3 : 32'd0);
        tick(1'b1, 1'b0, 1'b0, '0);
        check("dis_state", 32'(state), 32'd0);
        check("dis_kp", 32'(kp_out), 32'd0);
        check("dis_clear", 32'(loop_clear), 32'd0);
        check("dis_retries", 32'(acq_retries), TO_EN ? 32'd3 : 32'd0);

        // Reset in the middle of a TRACK window.
        tick(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < LC * WIN; i++) tick(1'b1, 1'b1, 1'b1, rand_err(16'h03FF));
        tick(1'b1, 1'b1, 1'b0, '0);
        check("mid_trk", 32'(state), 32'd2);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b1, rand_err(16'h03FF));
        tick(1'b0, 1'b1, 1'b1, 16'sh0100);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_kp", 32'(kp_out), 32'd0);
        check("mid_rst_metric", 32'(metric), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("reacq_state", 32'(state), 32'd1);
        check("reacq_clear", 32'(loop_clear), 32'd1);

        // Randomized regimes with occasional enable drops and threshold changes.
        for (int seg = 0; seg < 12; seg++) begin
            int lim, vpct;
            case ($urandom % 4)
                0:       lim = 16'h0200;
                1:       lim = 16'h0900;
                2:       lim = 16'h2800;
                default: lim = 32'h8000;
            endcase
            vpct = int'($urandom_range(50, 100));
            for (int c = 0; c < 400; c++) begin
                if ($urandom % 300 == 0) begin
                    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1, rand_err(lim));
                    lock_thr   = DW'($urandom_range(16'h0100, 16'h0800));
                    unlock_thr = lock_thr + DW'($urandom_range(0, 16'h0800));
                end
                tick(1'b1, 1'b1, ($urandom % 100) < vpct, rand_err(lim));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
